// File: rtl/match_logger_pkg.sv
// Shared defaults and sizing helpers for the match logger.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package match_logger_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int IDXW_DEF  = 8;
    localparam int CNTW_DEF  = 8;

    // Occupancy needs one extra bit so a full FIFO (level == DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/match_logger_fifo.sv
// Show-ahead FIFO holding the bit indices of logged matches.
// Latency: a pushed entry is visible one cycle after the push; a pop exposes the new head next cycle.
// Backpressure: push while full is dropped (drop_o pulses) unless a pop frees the slot the same cycle.
module match_fifo
    import match_logger_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = IDXW_DEF,
    localparam int LW    = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o,
    output logic          drop_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // Accept/reject decisions: a pop on empty is ignored, and a push on full only
    // proceeds when a real pop frees the head slot in the same cycle.
    always_comb begin
        do_pop   = pop_i && (cnt_q != '0);
        do_push  = push_i && ((cnt_q != LW'(DEPTH)) || do_pop);
        drop_o   = push_i && !do_push;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is suppressed so the
    // in-flight push leaves no trace.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign level_o  = cnt_q;
    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == LW'(DEPTH));

endmodule

// File: rtl/match_logger.sv
// Logs the serial bit index of every detector match into a FIFO, with a saturating match count.
// Latency: a match is visible at rd_data/level one cycle after the en&y edge.
// Backpressure: none upstream; matches arriving on a full FIFO are dropped and flagged in sticky overflow.
module match_logger
    import match_logger_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDXW  = IDXW_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     y,
    input  logic                     rd_en,
    output logic [IDXW-1:0]          rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic [CNTW-1:0]          match_count,
    output logic                     overflow
);

    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            match;
    logic            drop;

    assign match = en && y;

    // The pre-increment index is what gets logged, so the first consumed bit is index 0.
    match_fifo #(
        .DEPTH (DEPTH),
        .DW    (IDXW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (match),
        .push_dat_i (idx_q),
        .pop_i      (rd_en),
        .rd_dat_o   (rd_data),
        .empty_o    (empty),
        .full_o     (full),
        .level_o    (level),
        .drop_o     (drop)
    );

    // Next-state for bit index, saturating match counter (dropped matches included) and sticky overflow.
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | drop;
        if (en) begin
            idx_d = idx_q + IDXW'(1);
        end
        if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // State registers with synchronous reset overriding any concurrent match.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign match_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_logger.sv
// Directed bench for match_logger with default parameters (DEPTH=4, IDXW=8, CNTW=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Each scenario task performs its own comparisons.
module tb_match_logger;

    logic       clk;
    logic       rst;
    logic       en;
    logic       y;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic [7:0] match_count;
    logic       overflow;

    int total;
    int bad;

    match_logger dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .y           (y),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .match_count (match_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; y = 1'b0; rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; y = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; y = 1'b0; rd_en = 1'b0;
        total++;
        if ({empty, full, level, match_count, overflow} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: empty=%0b full=%0b level=%0d count=%0d ovf=%0b required 1 0 0 0 0",
                     empty, full, level, match_count, overflow);
        end
    endtask

    task automatic test_basic_log();
        do_reset();
        for (int k = 0; k < 64; k++) begin
            en = 1'b1;
            y  = (k == 5 || k == 9 || k == 20);
            tick();
        end
        en = 1'b0; y = 1'b0;
        total++;
        if (level !== 3'd3 || rd_data !== 8'd5 || match_count !== 8'd3 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_log: level=%0d rd_data=%0d count=%0d ovf=%0b required 3 5 3 0",
                     level, rd_data, match_count, overflow);
        end
        pop_one();
        total++;
        if (rd_data !== 8'd9 || level !== 3'd2) begin
            bad++;
            $display("FAIL basic_pop1: rd_data=%0d level=%0d required 9 2", rd_data, level);
        end
        pop_one();
        total++;
        if (rd_data !== 8'd20 || level !== 3'd1) begin
            bad++;
            $display("FAIL basic_pop2: rd_data=%0d level=%0d required 20 1", rd_data, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            en = 1'b1; y = 1'b1;
            tick();
        end
        en = 1'b0; y = 1'b0;
        total++;
        if (full !== 1'b1 || level !== 3'd4 || match_count !== 8'd6 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_state: full=%0b level=%0d count=%0d ovf=%0b required 1 4 6 1",
                     full, level, match_count, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rd_data !== 8'(k)) begin
                bad++;
                $display("FAIL overflow_order[%0d]: rd_data=%0d required %0d", k, rd_data, k);
            end
            pop_one();
        end
        total++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: empty=%0b ovf=%0b required 1 1", empty, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            en = 1'b1; y = 1'b1;
            tick();
        end
        en = 1'b1; y = 1'b1; rd_en = 1'b1;
        tick();
        en = 1'b0; y = 1'b0; rd_en = 1'b0;
        total++;
        if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || rd_data !== 8'd1) begin
            bad++;
            $display("FAIL full_push_pop: level=%0d full=%0b ovf=%0b rd_data=%0d required 4 1 0 1",
                     level, full, overflow, rd_data);
        end
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (rd_data !== 8'(k)) begin
                bad++;
                $display("FAIL full_drain[%0d]: rd_data=%0d required %0d", k, rd_data, k);
            end
            pop_one();
        end
        pop_one();
        total++;
        if (empty !== 1'b1 || level !== 3'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop_ignored: empty=%0b level=%0d ovf=%0b required 1 0 0",
                     empty, level, overflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            en = 1'b1;
            y  = (k == 255 || k == 256);
            tick();
        end
        en = 1'b0; y = 1'b0;
        total++;
        if (level !== 3'd2 || rd_data !== 8'd255) begin
            bad++;
            $display("FAIL wrap_first: level=%0d rd_data=%0d required 2 255", level, rd_data);
        end
        pop_one();
        total++;
        if (rd_data !== 8'd0 || level !== 3'd1) begin
            bad++;
            $display("FAIL wrap_second: rd_data=%0d level=%0d required 0 1", rd_data, level);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; y = 1'b0;
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            en = 1'b0; y = 1'b1;
            tick();
        end
        total++;
        if (level !== 3'd0 || empty !== 1'b1 || match_count !== 8'd0) begin
            bad++;
            $display("FAIL en_gating: level=%0d empty=%0b count=%0d required 0 1 0",
                     level, empty, match_count);
        end
        en = 1'b1; y = 1'b1;
        tick();
        en = 1'b0; y = 1'b0;
        total++;
        if (rd_data !== 8'd3 || match_count !== 8'd1) begin
            bad++;
            $display("FAIL en_idx_hold: rd_data=%0d count=%0d required 3 1", rd_data, match_count);
        end
    endtask

    task automatic test_back_to_back();
        // Level 2 holding {0,1}; push+pop keeps level and order: {1,2}.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            en = 1'b1; y = 1'b1;
            tick();
        end
        en = 1'b1; y = 1'b1; rd_en = 1'b1;
        tick();
        en = 1'b0; y = 1'b0; rd_en = 1'b0;
        total++;
        if (level !== 3'd2 || rd_data !== 8'd1) begin
            bad++;
            $display("FAIL mid_push_pop: level=%0d rd_data=%0d required 2 1", level, rd_data);
        end
        pop_one();
        total++;
        if (rd_data !== 8'd2 || level !== 3'd1) begin
            bad++;
            $display("FAIL mid_order: rd_data=%0d level=%0d required 2 1", rd_data, level);
        end
        // Saturation: 260 matches with rd_en held; first push lands in empty FIFO,
        // the rest are push+pop at level 1. Last logged index is 259 mod 256 = 3.
        do_reset();
        for (int k = 0; k < 260; k++) begin
            en = 1'b1; y = 1'b1; rd_en = 1'b1;
            tick();
        end
        en = 1'b0; y = 1'b0; rd_en = 1'b0;
        total++;
        if (match_count !== 8'd255 || level !== 3'd1 || rd_data !== 8'd3 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL saturate: count=%0d level=%0d rd_data=%0d ovf=%0b required 255 1 3 0",
                     match_count, level, rd_data, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            en = 1'b1; y = 1'b1;
            tick();
        end
        en = 1'b0; y = 1'b0;
        pop_one();
        pop_one();
        total++;
        if (level !== 3'd2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: level=%0d ovf=%0b required 2 1", level, overflow);
        end
        rst = 1'b1; en = 1'b1; y = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; y = 1'b0; rd_en = 1'b0;
        total++;
        if ({empty, full, level, match_count, overflow} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: empty=%0b full=%0b level=%0d count=%0d ovf=%0b required 1 0 0 0 0",
                     empty, full, level, match_count, overflow);
        end
        pop_one();
        total++;
        if (empty !== 1'b1 || level !== 3'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_rd: empty=%0b level=%0d ovf=%0b required 1 0 0",
                     empty, level, overflow);
        end
        en = 1'b1; y = 1'b1;
        tick();
        en = 1'b0; y = 1'b0;
        total++;
        if (rd_data !== 8'd0 || level !== 3'd1 || match_count !== 8'd1) begin
            bad++;
            $display("FAIL first_idx: rd_data=%0d level=%0d count=%0d required 0 1 1",
                     rd_data, level, match_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; en = 1'b0; y = 1'b0; rd_en = 1'b0;
        test_reset();
        test_basic_log();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_en_gating();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
